// File: rtl/ads8332_pkg.sv
// ads8332_pkg: shared constants, FSM state type and small helper functions
// for the ADS8332 SPI responder.
//   OP_*        command opcodes carried in bits [15:12] of the command word
//   CMD_BITS    number of SDI bits forming the command word
//   FRAME_BITS  total SCLK cycles in a well-formed frame
//   state_e     responder FSM states
package ads8332_pkg;

  localparam logic [3:0] OP_RD_CFR  = 4'hC;
  localparam logic [3:0] OP_WR_CFR  = 4'hE;
  localparam logic [3:0] OP_DEF_CFR = 4'hF;

  localparam int CMD_BITS   = 16;
  localparam int FRAME_BITS = 32;

  // Counter compare points, sized to the 6-bit bit counter.
  localparam logic [5:0] CNT_CMD_LAST   = 6'(CMD_BITS - 1);
  localparam logic [5:0] CNT_FRAME_LAST = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CNT_FRAME      = 6'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Second half of the SDO frame: CFR readback for the read opcode, else zero.
  function automatic logic [15:0] readback_word(input logic [3:0] op,
                                                input logic [11:0] cfr_val);
    if (op == OP_RD_CFR) begin
      return {4'h0, cfr_val};
    end else begin
      return 16'h0000;
    end
  endfunction

  // Opcodes 0x0-0x7 select a channel.
  function automatic logic is_ch_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/ads8332_spi_resp_edge_sync.sv
// spi_edge_sync: N-stage synchronizer for one asynchronous input with
// registered single-cycle rise/fall pulses.
//   clk      sampling clock
//   rst_n    synchronous active-low reset
//   async_in asynchronous input
//   level    synchronized level (STAGES cycles of latency)
//   rise     1-cycle pulse one cycle after level goes 0->1
//   fall     1-cycle pulse one cycle after level goes 1->0
// All stages reset to 0. For an active-low CS this means a CS already held
// low through reset produces no fall pulse; it must rise and fall again.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  // Next-state for the synchronizer chain and edge pulses.
  always_comb begin
    sync_d = {sync_q[N-2:0], async_in};
    prev_d = sync_q[N-1];
    rise_d = sync_q[N-1] & ~prev_q;
    fall_d = ~sync_q[N-1] & prev_q;
  end

  // Synchronizer and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[N-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ads8332_spi_resp.sv
// ads8332_spi_resp: ADS8332-style SPI responder for 32-bit frames
// (16-bit command in, 16-bit sample + 16-bit readback out), over-sampled
// in the spi_clk domain.
//   spi_clk         system clock (>= 4x SCLK)
//   sys_rest        synchronous active-low reset
//   ads_spi_clk/cs/sdi  asynchronous SPI inputs from the master
//   ads_spi_sdo     registered serial data to the master (0 when idle)
//   adc_data(_valid) conversion sample and its 1-cycle load strobe
//   ch_sel, cfr     channel select and configuration registers
//   cmd_word/cmd_valid  last decoded command and its update pulse
//   cmd_err         pulse on unsupported opcode
//   frame_err       pulse when CS rises on a frame that was not exactly 32 bits
//   busy            FSM not in IDLE
module ads8332_spi_resp
  import ads8332_pkg::*;
#(
  parameter logic [11:0] CFR_DEFAULT = 12'h7FF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        spi_clk,
  input  logic        sys_rest,
  input  logic        ads_spi_clk,
  input  logic        ads_spi_cs,
  input  logic        ads_spi_sdi,
  output logic        ads_spi_sdo,
  input  logic [15:0] adc_data,
  input  logic        adc_data_valid,
  output logic [2:0]  ch_sel,
  output logic [11:0] cfr,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        frame_err,
  output logic        busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(spi_clk), .rst_n(sys_rest), .async_in(ads_spi_clk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(spi_clk), .rst_n(sys_rest), .async_in(ads_spi_cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(spi_clk), .rst_n(sys_rest), .async_in(ads_spi_sdi),
    .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign unused_s = ^{sclk_lvl, cs_lvl, sdi_rise, sdi_fall};

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ovr_q, ovr_d;        // SCLK rise seen after bit 32
  logic [15:0] cmd_sh_q, cmd_sh_d;
  logic [15:0] tx_sh_q, tx_sh_d;    // bits still to be sent, MSB next
  logic        sdo_q, sdo_d;
  logic [15:0] hold_q, hold_d;
  logic [2:0]  ch_sel_q, ch_sel_d;
  logic [11:0] cfr_q, cfr_d;
  logic [15:0] cmd_word_q, cmd_word_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_err_q, cmd_err_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic [15:0] word_s;

  // Command word as it stands once the current SDI bit is shifted in.
  assign word_s = {cmd_sh_q[14:0], sdi_lvl};

  // FSM next-state, shifters, command decode and output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    cmd_sh_d    = cmd_sh_q;
    tx_sh_d     = tx_sh_q;
    sdo_d       = sdo_q;
    ch_sel_d    = ch_sel_q;
    cfr_d       = cfr_q;
    cmd_word_d  = cmd_word_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    frame_err_d = 1'b0;

    // A sample strobed in the snapshot cycle is taken by the snapshot,
    // because the snapshot reads hold_d rather than hold_q.
    if (adc_data_valid) begin
      hold_d = adc_data;
    end else begin
      hold_d = hold_q;
    end

    if (cs_rise) begin
      state_d = ST_IDLE;
      sdo_d   = 1'b0;
      // Overlong frames saturate the counter at 32, so ovr_q flags them.
      if ((state_q != ST_IDLE) && ((cnt_q != CNT_FRAME) || ovr_q)) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          sdo_d = 1'b0;
          if (cs_fall) begin
            state_d  = ST_CMD;
            cnt_d    = 6'd0;
            ovr_d    = 1'b0;
            cmd_sh_d = 16'h0000;
            sdo_d    = hold_d[15];
            tx_sh_d  = {hold_d[14:0], 1'b0};
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            cmd_sh_d = word_s;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == CNT_CMD_LAST) begin
              state_d     = ST_DATA;
              cmd_word_d  = word_s;
              cmd_valid_d = 1'b1;
              // SDO still holds bit 15; the readback goes out from the next fall.
              tx_sh_d     = readback_word(word_s[15:12], cfr_q);
              if (is_ch_op(word_s[15:12])) begin
                ch_sel_d = word_s[14:12];
              end else begin
                case (word_s[15:12])
                  OP_RD_CFR:  cfr_d     = cfr_q;
                  OP_WR_CFR:  cfr_d     = word_s[11:0];
                  OP_DEF_CFR: cfr_d     = CFR_DEFAULT;
                  default:    cmd_err_d = 1'b1;
                endcase
              end
            end else begin
              state_d = ST_CMD;
            end
          end else if (sclk_fall) begin
            sdo_d   = tx_sh_q[15];
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
          end else begin
            state_d = ST_CMD;
          end
        end

        ST_DATA: begin
          if (sclk_rise) begin
            if (cnt_q >= CNT_FRAME) begin
              cnt_d = CNT_FRAME;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
            if (cnt_q == CNT_FRAME_LAST) begin
              state_d = ST_DONE;
              sdo_d   = 1'b0;
            end else begin
              state_d = ST_DATA;
            end
          end else if (sclk_fall) begin
            sdo_d   = tx_sh_q[15];
            tx_sh_d = {tx_sh_q[14:0], 1'b0};
          end else begin
            state_d = ST_DATA;
          end
        end

        ST_DONE: begin
          sdo_d = 1'b0;
          if (sclk_rise) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
          sdo_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge spi_clk) begin
    if (!sys_rest) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      ovr_q       <= 1'b0;
      cmd_sh_q    <= 16'h0000;
      tx_sh_q     <= 16'h0000;
      sdo_q       <= 1'b0;
      hold_q      <= 16'h0000;
      ch_sel_q    <= 3'd0;
      cfr_q       <= CFR_DEFAULT;
      cmd_word_q  <= 16'h0000;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      cmd_sh_q    <= cmd_sh_d;
      tx_sh_q     <= tx_sh_d;
      sdo_q       <= sdo_d;
      hold_q      <= hold_d;
      ch_sel_q    <= ch_sel_d;
      cfr_q       <= cfr_d;
      cmd_word_q  <= cmd_word_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ads_spi_sdo = sdo_q;
  assign ch_sel      = ch_sel_q;
  assign cfr         = cfr_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_err     = cmd_err_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule
